// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types for the dual-core data-memory arbiter
package cpu_types_pkg;

    localparam int NCORES      = 2;
    localparam int RESV_ADDR_W = 30;

    typedef logic [RESV_ADDR_W-1:0] resv_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

endpackage

// File: rtl/reservation_unit.sv
// rtl/reservation_unit.sv - one LR/SC reservation slot (word address + valid)
module reservation_unit
    import cpu_types_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       set,
    input  logic       clear_own,
    input  logic       snoop_wen,
    input  resv_addr_t snoop_addr,
    input  resv_addr_t check_addr,
    output logic       match,
    output logic       valid
);

    resv_addr_t addr_q;

    // LR sets, own SC clears, and any committed write to the reserved word kills it
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid  <= 1'b0;
            addr_q <= '0;
        end else if (set) begin
            valid  <= 1'b1;
            addr_q <= snoop_addr;
        end else if (clear_own) begin
            valid  <= 1'b0;
        end else if (snoop_wen && (addr_q == snoop_addr)) begin
            valid  <= 1'b0;
        end
    end

    assign match = valid && (addr_q == check_addr);

endmodule

// File: rtl/dual_core_mem_arbiter.sv
// rtl/dual_core_mem_arbiter.sv - round-robin data-memory arbiter with LR/SC reservations (optional perf counters: DUAL_CORE_ARB_PERF_EN)
module dual_core_mem_arbiter
    import cpu_types_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NCORES-1:0]       creq_ren,
    input  logic [NCORES-1:0]       creq_wen,
    input  logic [NCORES-1:0]       creq_lr,
    input  logic [NCORES-1:0]       creq_sc,
    input  logic [NCORES-1:0][31:0] creq_addr,
    input  logic [NCORES-1:0][31:0] creq_store,
    output logic [NCORES-1:0]       cresp_ready,
    output logic [NCORES-1:0][31:0] cresp_load,
`ifdef DUAL_CORE_ARB_PERF_EN
    output logic [NCORES-1:0][31:0] perf_grants,
    output logic [NCORES-1:0][31:0] perf_wait,
`endif
    output logic                    mem_ren,
    output logic                    mem_wen,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_store,
    input  logic [31:0]             mem_load,
    input  logic                    mem_ready
);

    arb_state_t              state, state_nxt;
    logic                    grant;
    logic                    last_grant;
    logic                    fail_q;
    logic [NCORES-1:0]       req;
    logic [NCORES-1:0]       match;
    logic [NCORES-1:0]       resv_valid;
    logic [NCORES-1:0][31:0] load_q;
    logic                    pick;
    logic                    pick_sc_fail;
    logic                    in_done;
    logic                    done_set;
    logic                    done_clear_own;
    logic                    done_snoop;
    resv_addr_t              done_word;

    assign req  = creq_ren | creq_wen;
    // On a tie the core that did not win last time gets the port
    assign pick = (req == 2'b11) ? ~last_grant : req[1];
    // SC without a live matching reservation is resolved without touching RAM
    assign pick_sc_fail = creq_wen[pick] & creq_sc[pick] & ~match[pick];

    // State register; async reset drops the strobes mid-access
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, RAM strobes and completion pulse
    always_comb begin
        state_nxt   = state;
        mem_ren     = 1'b0;
        mem_wen     = 1'b0;
        mem_addr    = '0;
        mem_store   = '0;
        cresp_ready = '0;
        case (state)
            IDLE: begin
                if (|req) state_nxt = pick_sc_fail ? DONE : ACCESS;
            end
            ACCESS: begin
                mem_ren   = creq_ren[grant];
                mem_wen   = creq_wen[grant];
                mem_addr  = creq_addr[grant];
                mem_store = creq_store[grant];
                if (mem_ready) state_nxt = DONE;
            end
            DONE: begin
                cresp_ready[grant] = 1'b1;
                state_nxt          = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant bookkeeping and per-core response data
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            fail_q     <= 1'b0;
            load_q     <= '0;
        end else if (state == IDLE) begin
            if (|req) begin
                grant      <= pick;
                last_grant <= pick;
                fail_q     <= pick_sc_fail;
                if (pick_sc_fail) load_q[pick] <= 32'd1;
            end
        end else if (state == ACCESS) begin
            if (mem_ready) load_q[grant] <= creq_ren[grant] ? mem_load : 32'd0;
        end
    end

    assign cresp_load = load_q;

    // Reservation updates land on the DONE cycle; the request is still held then
    assign in_done        = (state == DONE);
    assign done_word      = creq_addr[grant][31:2];
    assign done_set       = in_done & creq_ren[grant] & creq_lr[grant];
    assign done_clear_own = in_done & creq_wen[grant] & creq_sc[grant];
    assign done_snoop     = in_done & creq_wen[grant] & ~fail_q;

    for (genvar i = 0; i < NCORES; i++) begin : g_resv
        reservation_unit u_resv (
            .CLK        (CLK),
            .RST        (RST),
            .set        (done_set && (grant == 1'(i))),
            .clear_own  (done_clear_own && (grant == 1'(i))),
            .snoop_wen  (done_snoop),
            .snoop_addr (done_word),
            .check_addr (creq_addr[i][31:2]),
            .match      (match[i]),
            .valid      (resv_valid[i])
        );
    end

`ifdef DUAL_CORE_ARB_PERF_EN
    // Completions per core, and cycles a core spends requesting before its pulse
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_grants <= '0;
            perf_wait   <= '0;
        end else begin
            for (int i = 0; i < NCORES; i++) begin
                if (cresp_ready[i])             perf_grants[i] <= perf_grants[i] + 32'd1;
                if (req[i] && !cresp_ready[i])  perf_wait[i]   <= perf_wait[i] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// tb/tb_dual_core_mem_arbiter.sv - self-checking bench for dual_core_mem_arbiter
module tb_dual_core_mem_arbiter;
    import cpu_types_pkg::*;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [1:0]       creq_ren, creq_wen, creq_lr, creq_sc;
    logic [1:0][31:0] creq_addr, creq_store;
    logic [1:0]       cresp_ready;
    logic [1:0][31:0] cresp_load;
    logic             mem_ren, mem_wen, mem_ready;
    logic [31:0]      mem_addr, mem_store, mem_load;
`ifdef DUAL_CORE_ARB_PERF_EN
    logic [1:0][31:0] perf_grants, perf_wait;
`endif

    dual_core_mem_arbiter dut (
        .CLK         (CLK),
        .RST         (RST),
        .creq_ren    (creq_ren),
        .creq_wen    (creq_wen),
        .creq_lr     (creq_lr),
        .creq_sc     (creq_sc),
        .creq_addr   (creq_addr),
        .creq_store  (creq_store),
        .cresp_ready (cresp_ready),
        .cresp_load  (cresp_load),
`ifdef DUAL_CORE_ARB_PERF_EN
        .perf_grants (perf_grants),
        .perf_wait   (perf_wait),
`endif
        .mem_ren     (mem_ren),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_store   (mem_store),
        .mem_load    (mem_load),
        .mem_ready   (mem_ready)
    );

    initial forever #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // RAM seen by the DUT, and the bench's own view of architectural memory
    logic [31:0] ram[int];
    logic [31:0] mdl[int];
    bit          mv[2];
    int          ma[2];
    bit          txn_wrote;
    logic [31:0] last_wr_addr, last_wr_data;
    int          wr_count = 0;
    int          acc_cnt  = 0;
    int          ram_wait = 0;
    int          pulses[2];

    // Reference behaviour for one completion of core c
    task automatic model_pulse(input int c);
        int          w;
        bit          succ;
        logic [31:0] exp;
        w = int'(creq_addr[c][31:2]);
        pulses[c]++;
        chk("pulse_has_req", {31'b0, creq_ren[c] | creq_wen[c]}, 32'd1);
        if (creq_ren[c]) begin
            exp = mdl.exists(w) ? mdl[w] : 32'd0;
            chk("model_load", cresp_load[c], exp);
            chk("read_no_write", {31'b0, txn_wrote}, 32'd0);
            if (creq_lr[c]) begin
                mv[c] = 1'b1;
                ma[c] = w;
            end
        end else begin
            succ = !creq_sc[c] || (mv[c] && ma[c] == w);
            if (creq_sc[c]) begin
                chk("model_sc", cresp_load[c], succ ? 32'd0 : 32'd1);
                mv[c] = 1'b0;
            end
            chk("wrote_iff_success", {31'b0, txn_wrote}, {31'b0, succ});
            if (succ) begin
                chk("model_wr_addr", last_wr_addr, creq_addr[c]);
                chk("model_wr_data", last_wr_data, creq_store[c]);
                mdl[w] = creq_store[c];
                for (int k = 0; k < 2; k++) if (ma[k] == w) mv[k] = 1'b0;
            end
        end
        txn_wrote = 1'b0;
    endtask

    // Per-cycle compare against the model, then the RAM responder
    initial begin
        mem_ready = 1'b0;
        mem_load  = 32'd0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                mv[0] = 1'b0; mv[1] = 1'b0;
                txn_wrote = 1'b0;
                acc_cnt   = 0;
                mem_ready = 1'b0;
            end else begin
                chk("strobe_exclusive", {31'b0, mem_ren & mem_wen}, 32'd0);
                chk("pulse_onehot", {31'b0, cresp_ready == 2'b11}, 32'd0);
                for (int c = 0; c < 2; c++) begin
                    chk("req_legal", {31'b0, creq_ren[c] & creq_wen[c]}, 32'd0);
                    if (cresp_ready[c]) model_pulse(c);
                end
                if (mem_ren || mem_wen) begin
                    acc_cnt++;
                    if (acc_cnt > ram_wait) begin
                        mem_ready = 1'b1;
                        if (mem_ren) begin
                            mem_load = ram.exists(int'(mem_addr[31:2])) ? ram[int'(mem_addr[31:2])] : 32'd0;
                        end else begin
                            ram[int'(mem_addr[31:2])] = mem_store;
                            txn_wrote    = 1'b1;
                            last_wr_addr = mem_addr;
                            last_wr_data = mem_store;
                            wr_count++;
                        end
                    end else begin
                        mem_ready = 1'b0;
                        mem_load  = 32'hBAD0_BAD0;
                    end
                end else begin
                    acc_cnt   = 0;
                    mem_ready = 1'b0;
                    mem_load  = 32'hBAD0_BAD0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Drive one request, wait (bounded) for its pulse; lat counts the request cycle as 1
    task automatic issue(input int c, input bit ren, input bit wen, input bit lr, input bit sc,
                         input logic [31:0] addr, input logic [31:0] data,
                         output int lat, output logic [31:0] load);
        bit got;
        creq_ren[c] = ren; creq_wen[c] = wen; creq_lr[c] = lr; creq_sc[c] = sc;
        creq_addr[c] = addr; creq_store[c] = data;
        got = 1'b0; lat = 0; load = 32'd0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge CLK);
            if (cresp_ready[c]) begin
                got  = 1'b1;
                lat  = i;
                load = cresp_load[c];
            end
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL issue_timeout core=%0d actual=no_pulse required=pulse", c);
        end
        @(posedge CLK); #1;
        creq_ren[c] = 1'b0; creq_wen[c] = 1'b0; creq_lr[c] = 1'b0; creq_sc[c] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK); #2 RST = 1'b1;
        @(negedge CLK); #2 RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    int          lat, np, start, p1, wc, psum;
    logic [31:0] load;
    int          pcore[4], pcyc[4];
    bit          seen;

    initial begin
        creq_ren = '0; creq_wen = '0; creq_lr = '0; creq_sc = '0;
        creq_addr = '0; creq_store = '0;
        pulses[0] = 0; pulses[1] = 0;
        ma[0] = -1; ma[1] = -1;
        ram[32'h40] = 32'hDEAD_BEEF; mdl[32'h40] = 32'hDEAD_BEEF;
        ram[32'h41] = 32'h1234_5678; mdl[32'h41] = 32'h1234_5678;
        ram[32'h80] = 32'hA5A5_A5A5; mdl[32'h80] = 32'hA5A5_A5A5;
        ram[32'hC0] = 32'h0C0C_0C0C; mdl[32'hC0] = 32'h0C0C_0C0C;
        ram[32'hC1] = 32'h1111_1111; mdl[32'hC1] = 32'h1111_1111;

        repeat (2) @(posedge CLK); #1;
        chk("rst_mem_ren", {31'b0, mem_ren}, 32'd0);
        chk("rst_mem_wen", {31'b0, mem_wen}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_store", mem_store, 32'd0);
        chk("rst_cresp_ready", {30'b0, cresp_ready}, 32'd0);
        chk("rst_cresp_load0", cresp_load[0], 32'd0);
        chk("rst_cresp_load1", cresp_load[1], 32'd0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_resv_valid", {30'b0, dut.resv_valid}, 32'd0);
        @(negedge CLK); #2 RST = 1'b0;
        @(posedge CLK); #1;

        // Tie fairness straight out of reset
        ram_wait = 0;
        creq_addr[0] = 32'h100; creq_addr[1] = 32'h104;
        creq_ren = 2'b11;
        start = cyc; np = 0;
        for (int i = 0; i < 40 && np < 4; i++) begin
            @(negedge CLK);
            if (cresp_ready != 2'b00) begin
                pcore[np] = cresp_ready[1] ? 1 : 0;
                pcyc[np]  = cyc;
                np++;
            end
        end
        @(posedge CLK); #1;
        creq_ren = 2'b00;
        chk("tie_pulse_count", np, 4);
        if (np == 4) begin
            chk("tie_first_latency", pcyc[0] - start + 1, 3);
            for (int k = 0; k < 4; k++) chk("tie_grant_order", pcore[k], k % 2);
            for (int k = 1; k < 4; k++) chk("tie_spacing", pcyc[k] - pcyc[k-1], 3);
        end
        repeat (2) @(posedge CLK); #1;

        // Single LW with two wait cycles
        ram_wait = 2;
        p1 = pulses[1];
        issue(0, 1, 0, 0, 0, 32'h100, 32'h0, lat, load);
        chk("lw_latency", lat, 5);
        chk("lw_data", load, 32'hDEAD_BEEF);
        chk("lw_core1_quiet", pulses[1], p1);

        // LR/SC success
        ram_wait = 1;
        issue(0, 1, 0, 1, 0, 32'h200, 32'h0, lat, load);
        chk("lr_latency", lat, 4);
        chk("lr_data", load, 32'hA5A5_A5A5);
        wc = wr_count;
        issue(0, 0, 1, 0, 1, 32'h200, 32'h5, lat, load);
        chk("sc_ok_result", load, 32'd0);
        chk("sc_ok_one_write", wr_count, wc + 1);
        chk("sc_ok_store", last_wr_data, 32'h5);
        chk("sc_ok_addr", last_wr_addr, 32'h200);
        chk("sc_ok_resv_cleared", {31'b0, dut.resv_valid[0]}, 32'd0);

        // Cross-core kill
        ram_wait = 0;
        issue(0, 1, 0, 1, 0, 32'h200, 32'h0, lat, load);
        chk("kill_lr_data", load, 32'h5);
        issue(1, 0, 1, 0, 0, 32'h200, 32'h77, lat, load);
        wc = wr_count;
        issue(0, 0, 1, 0, 1, 32'h200, 32'h9, lat, load);
        chk("kill_sc_result", load, 32'd1);
        chk("kill_sc_latency", lat, 2);
        chk("kill_sc_no_write", wr_count, wc);

        // Mismatched SC and a store to a neighbouring word
        issue(1, 1, 0, 1, 0, 32'h300, 32'h0, lat, load);
        chk("mis_lr_data", load, 32'h0C0C_0C0C);
        issue(1, 0, 1, 0, 0, 32'h304, 32'h11, lat, load);
        chk("mis_resv_kept", {31'b0, dut.resv_valid[1]}, 32'd1);
        issue(1, 0, 1, 0, 1, 32'h304, 32'h22, lat, load);
        chk("mis_sc_result", load, 32'd1);
        issue(1, 0, 1, 0, 1, 32'h300, 32'h33, lat, load);
        chk("sc_after_fail_result", load, 32'd1);

        // Async reset in the middle of a long read
        issue(1, 1, 0, 1, 0, 32'h300, 32'h0, lat, load);
        ram_wait = 10;
        psum = pulses[0] + pulses[1];
        creq_ren[0] = 1'b1; creq_addr[0] = 32'h104;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            seen = mem_ren;
        end
        chk("arst_mem_ren_before", {31'b0, mem_ren}, 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("arst_mem_ren_async_drop", {31'b0, mem_ren}, 32'd0);
        creq_ren[0] = 1'b0;
        @(negedge CLK); #2 RST = 1'b0;
        @(posedge CLK); #1;
        chk("arst_state", 32'(dut.state), 32'(IDLE));
        chk("arst_resv_valid", {30'b0, dut.resv_valid}, 32'd0);
`ifdef DUAL_CORE_ARB_PERF_EN
        chk("arst_perf_grants0", perf_grants[0], 32'd0);
        chk("arst_perf_grants1", perf_grants[1], 32'd0);
`endif
        repeat (5) @(posedge CLK); #1;
        chk("arst_no_pulse", pulses[0] + pulses[1], psum);

        ram_wait = 0;
        issue(1, 0, 1, 0, 1, 32'h300, 32'h44, lat, load);
        chk("sc_after_reset_result", load, 32'd1);
`ifdef DUAL_CORE_ARB_PERF_EN
        do_reset();
        issue(0, 1, 0, 0, 0, 32'h104, 32'h0, lat, load);
        chk("perf_grants_one", perf_grants[0], 32'd1);
        chk("perf_wait_two", perf_wait[0], 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
